// File: rtl/ysyx_24080006_mdu_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer and
// its borrowed-adder side port to the ALU.
package ysyx_24080006_mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ABS_A   = 3'd1,
      S_ABS_B   = 3'd2,
      S_SPECIAL = 3'd3,
      S_ITER    = 3'd4,
      S_FIX_LO  = 3'd5,
      S_FIX_HI  = 3'd6,
      S_DONE    = 3'd7
   } mdu_state_e;

   typedef struct packed {
      logic [32:0] a;
      logic [32:0] b;
   } mdu2alu_t;

   typedef struct packed {
      logic [33:0] res_34;
      logic [31:0] res_32;
      logic        not_zero;
   } alu2mdu_t;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   function automatic logic op_is_div(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
   endfunction

   function automatic logic op_is_rem(input mdu_op_e op);
      return (op == MDU_REM) || (op == MDU_REMU);
   endfunction

   function automatic logic op_a_signed(input mdu_op_e op);
      return (op != MDU_MULHU) && (op != MDU_DIVU) && (op != MDU_REMU);
   endfunction

   function automatic logic op_b_signed(input mdu_op_e op);
      return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_ctrl_if.sv
// Issue/result handshake plus the ALU adder side port of the MDU.
interface ysyx_24080006_mdu_ctrl_if;
   import ysyx_24080006_mdu_ctrl_pkg::*;

   logic        in_valid;
   logic        in_ready;
   mdu_op_e     in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic        mdu_enable;
   mdu2alu_t    mdu2alu;
   alu2mdu_t    alu2mdu;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready, alu2mdu,
      input  in_ready, out_valid, out_res, mdu_enable, mdu2alu
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready, alu2mdu,
      output in_ready, out_valid, out_res, mdu_enable, mdu2alu
   );

endinterface

// File: rtl/ysyx_24080006_mdu_fsm.sv
// Sequencer state register and 32-step iteration counter for the MDU.
module ysyx_24080006_mdu_fsm
   import ysyx_24080006_mdu_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       flush_i,
   input  logic       start_i,
   input  logic       special_i,
   input  logic       abs_a_i,
   input  logic       abs_b_i,
   input  logic       sb_i,
   input  logic       fix_lo_i,
   input  logic       fix_hi_i,
   input  logic       out_ready_i,
   output mdu_state_e state_o
);

   mdu_state_e state_q;
   logic [4:0] cnt_q;

   // State and counter update; flush behaves exactly like reset.
   always_ff @(posedge clock) begin
      if (reset || flush_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= 5'd0;
               if (start_i) begin
                  if (special_i)    state_q <= S_SPECIAL;
                  else if (abs_a_i) state_q <= S_ABS_A;
                  else if (abs_b_i) state_q <= S_ABS_B;
                  else              state_q <= S_ITER;
               end
            end
            S_ABS_A:   state_q <= sb_i ? S_ABS_B : S_ITER;
            S_ABS_B:   state_q <= S_ITER;
            S_SPECIAL: state_q <= S_DONE;
            S_ITER: begin
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= fix_lo_i ? S_FIX_LO : S_DONE;
            end
            S_FIX_LO:  state_q <= fix_hi_i ? S_FIX_HI : S_DONE;
            S_FIX_HI:  state_q <= S_DONE;
            S_DONE:    if (out_ready_i) state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// RV32M multi-cycle multiply/divide unit; borrows the ALU's 33-bit adder
// for operand negation, shift-add multiply and restoring divide.
module ysyx_24080006_mdu_ctrl
   import ysyx_24080006_mdu_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic flush,
   ysyx_24080006_mdu_ctrl_if.slave io
);

   mdu_state_e  state_q;
   mdu_op_e     op_q;
   logic [31:0] hi_q, lo_q, b_q;
   logic        sa_q, sb_q, carry_q;

   logic        a_neg_d, b_neg_d, div_zero_d, div_ovf_d;
   logic        fix_lo_d, fix_hi_d, accept_d;
   logic [31:0] div_shift_d, res_sel_d;
   logic [32:0] alu_a_d, alu_b_d;

   // Issue-time classification and fix-stage selection.
   always_comb begin
      a_neg_d    = op_a_signed(io.in_op) & io.in_a[31];
      b_neg_d    = op_b_signed(io.in_op) & io.in_b[31];
      div_zero_d = op_is_div(io.in_op) & (io.in_b == 32'd0);
      div_ovf_d  = op_is_div(io.in_op) & op_b_signed(io.in_op)
                   & (io.in_a == INT_MIN) & (io.in_b == 32'hFFFF_FFFF);
      fix_lo_d   = op_is_rem(op_q) ? sa_q : (sa_q ^ sb_q);
      fix_hi_d   = ~op_is_div(op_q);
   end

   ysyx_24080006_mdu_fsm u_fsm (
      .clock      (clock),
      .reset      (reset),
      .flush_i    (flush),
      .start_i    (io.in_valid),
      .special_i  (div_zero_d | div_ovf_d),
      .abs_a_i    (a_neg_d),
      .abs_b_i    (b_neg_d),
      .sb_i       (sb_q),
      .fix_lo_i   (fix_lo_d),
      .fix_hi_i   (fix_hi_d),
      .out_ready_i(io.out_ready),
      .state_o    (state_q)
   );

   // Adder operand steering; only registered state feeds the ALU.
   always_comb begin
      div_shift_d = {hi_q[30:0], lo_q[31]};
      alu_a_d     = 33'd0;
      alu_b_d     = 33'd0;
      case (state_q)
         S_ABS_A: begin
            alu_a_d = {~lo_q, 1'b1};
            alu_b_d = {32'd0, 1'b1};
         end
         S_ABS_B: begin
            alu_a_d = {~b_q, 1'b1};
            alu_b_d = {32'd0, 1'b1};
         end
         S_ITER: begin
            if (op_is_div(op_q)) begin
               alu_a_d = {div_shift_d, 1'b1};
               alu_b_d = {~b_q, 1'b1};
            end else begin
               alu_a_d = {hi_q, 1'b1};
               alu_b_d = {(lo_q[0] ? b_q : 32'd0), 1'b0};
            end
         end
         S_FIX_LO: begin
            alu_a_d = op_is_rem(op_q) ? {~hi_q, 1'b1} : {~lo_q, 1'b1};
            alu_b_d = {32'd0, 1'b1};
         end
         S_FIX_HI: begin
            alu_a_d = {~hi_q, 1'b1};
            alu_b_d = {32'd0, carry_q};
         end
         default: begin
            alu_a_d = 33'd0;
            alu_b_d = 33'd0;
         end
      endcase
   end

   // A shifted partial remainder with bit 32 set always exceeds the divisor.
   assign accept_d = hi_q[31] | io.alu2mdu.res_34[33];

   // Datapath registers: hi holds product-high/remainder, lo holds multiplier/quotient.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         op_q    <= MDU_MUL;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         b_q     <= 32'd0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io.in_valid) begin
                  op_q <= io.in_op;
                  sa_q <= a_neg_d;
                  sb_q <= b_neg_d;
                  b_q  <= io.in_b;
                  if (div_zero_d) begin
                     lo_q <= DIV0_QUOT;
                     hi_q <= io.in_a;
                  end else if (div_ovf_d) begin
                     lo_q <= INT_MIN;
                     hi_q <= 32'd0;
                  end else begin
                     lo_q <= io.in_a;
                     hi_q <= 32'd0;
                  end
               end
            end
            S_ABS_A: lo_q <= io.alu2mdu.res_32;
            S_ABS_B: b_q  <= io.alu2mdu.res_32;
            S_ITER: begin
               if (op_is_div(op_q)) begin
                  hi_q <= accept_d ? io.alu2mdu.res_32 : div_shift_d;
                  lo_q <= {lo_q[30:0], accept_d};
               end else begin
                  hi_q <= {io.alu2mdu.res_34[33], io.alu2mdu.res_32[31:1]};
                  lo_q <= {io.alu2mdu.res_32[0], lo_q[31:1]};
               end
            end
            S_FIX_LO: begin
               if (op_is_rem(op_q)) begin
                  hi_q <= io.alu2mdu.res_32;
               end else begin
                  lo_q    <= io.alu2mdu.res_32;
                  carry_q <= io.alu2mdu.res_34[33];
               end
            end
            S_FIX_HI: hi_q <= io.alu2mdu.res_32;
            default: ;
         endcase
      end
   end

   // Result select; registers are frozen in DONE so the value is stable.
   always_comb begin
      case (op_q)
         MDU_MUL, MDU_DIV, MDU_DIVU: res_sel_d = lo_q;
         default:                    res_sel_d = hi_q;
      endcase
   end

   assign io.in_ready   = (state_q == S_IDLE);
   assign io.out_valid  = (state_q == S_DONE);
   assign io.out_res    = (state_q == S_DONE) ? res_sel_d : 32'd0;
   assign io.mdu_enable = (state_q == S_ABS_A) || (state_q == S_ABS_B) || (state_q == S_ITER)
                          || (state_q == S_FIX_LO) || (state_q == S_FIX_HI);
   assign io.mdu2alu    = {alu_a_d, alu_b_d};

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Directed bench for the MDU sequencer with a behavioural ALU adder.
module tb_ysyx_24080006_mdu_ctrl;
   import ysyx_24080006_mdu_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset;
   logic flush;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat;
   int   en_cnt;
   int   seen;

   always #5 clock = ~clock;

   ysyx_24080006_mdu_ctrl_if bus ();

   // ALU adder shared with the MDU: res_32 drops the carry-in slot bit 0.
   logic [33:0] alu_sum;
   assign alu_sum     = {1'b0, bus.mdu2alu.a} + {1'b0, bus.mdu2alu.b};
   assign bus.alu2mdu = {alu_sum, alu_sum[32:1], |alu_sum[32:1]};

   ysyx_24080006_mdu_ctrl dut (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .io   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Latency counts the accept edge as 1; bounded so a stuck DUT still ends.
   task automatic wait_valid();
      lat    = 1;
      en_cnt = 0;
      while (bus.out_valid !== 1'b1 && lat < 64) begin
         if (bus.mdu_enable === 1'b1) en_cnt++;
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic handshake(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "/in_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
      check({tag, "/valid_after"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   task automatic run(input string tag, input mdu_op_e op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      check({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      issue(op, a, b);
      wait_valid();
      check({tag, "/res"}, bus.out_res, exp);
      check({tag, "/lat"}, lat, exp_lat);
      handshake(tag);
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_op     = MDU_MUL;
      bus.in_a      = 32'd0;
      bus.in_b      = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      check("rst/in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst/out_res", bus.out_res, 32'd0);
      check("rst/mdu_enable", {31'd0, bus.mdu_enable}, 32'd0);
      check("rst/mdu2alu", {31'd0, |bus.mdu2alu}, 32'd0);

      run("mulhu_max", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      check("mulhu_max/en_cycles", en_cnt, 32'd32);
      run("mul_neg3x7", MDU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 36);
      run("mulh_neg3x7", MDU_MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 36);
      run("mulh_bothneg", MDU_MULH, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 35);
      run("mulhsu_neg", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 36);
      run("mulhu_2p32", MDU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);
      run("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
      run("rem_neg7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
      run("div_7_neg2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
      run("rem_7_neg2", MDU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
      run("divu_max_1", MDU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      run("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, 33);
      run("div_by0", MDU_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
      run("remu_by0", MDU_REMU, 32'd5, 32'd0, 32'd5, 2);
      run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      check("div_ovf/en_cycles", en_cnt, 32'd0);
      run("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

      // Flush in the 10th ITER cycle drops the operation.
      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clock);
      #1;
      check("flush/en_before", {31'd0, bus.mdu_enable}, 32'd1);
      @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      check("flush/in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("flush/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush/mdu_enable", {31'd0, bus.mdu_enable}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      check("flush/no_result", seen, 32'd0);
      run("after_flush", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // Reset mid-operation behaves like flush.
      issue(MDU_MUL, 32'd123, 32'd456);
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset/in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset/mdu_enable", {31'd0, bus.mdu_enable}, 32'd0);
      check("reset/out_res", bus.out_res, 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      check("reset/no_result", seen, 32'd0);
      run("after_reset", MDU_MUL, 32'd123, 32'd456, 32'd56088, 33);

      // Backpressure: result and in_ready held while out_ready is low.
      issue(MDU_MULHU, 32'h1234_5678, 32'h0000_0010);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check("bp/out_res", bus.out_res, 32'd1);
         check("bp/out_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp/in_ready", {31'd0, bus.in_ready}, 32'd0);
         @(posedge clock);
         #1;
      end
      handshake("bp");

      // Flush wins over out_ready in DONE.
      issue(MDU_DIV, 32'd9, 32'd0);
      wait_valid();
      check("flush_done/valid", {31'd0, bus.out_valid}, 32'd1);
      @(negedge clock);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      flush         = 1'b0;
      bus.out_ready = 1'b0;
      check("flush_done/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_done/in_ready", {31'd0, bus.in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
